fifo_control: RTL



---
 rtl/fifo_control_pkg.sv | 15 +
 rtl/fifo_ptr.sv | 35 +++
 rtl/fifo_control.sv | 106 ++++++++++
 3 files changed

// File: rtl/fifo_control_pkg.sv
// Shared defaults and types for the FIFO pointer/flag controller and its
// pointer sub-module.
package fifo_control_pkg;

  localparam int FIFO_DATA_WIDTH = 12;
  localparam int FIFO_ADDR_WIDTH = 8;
  localparam int FIFO_AF_MARGIN  = 2;
  localparam int FIFO_AE_MARGIN  = 2;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping address counter with enable and synchronous reset; one instance
// each for the memory write and read addresses.
module fifo_ptr
  import fifo_control_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] ptr
);

  localparam logic [ADDR_WIDTH-1:0] ONE_C = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  // Wrap from all-ones back to zero falls out of the modulo-2**N add.
  always_comb begin
    ptr_d = ptr_q;
    if (en) begin
      ptr_d = ptr_q + ONE_C;
    end
    if (reset) begin
      ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_control.sv
// Access-side controller for a FIFO storage memory: pointers, strobes,
// occupancy count, status flags and sticky error bits.
module fifo_control
  import fifo_control_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int AF_MARGIN  = FIFO_AF_MARGIN,
  parameter int AE_MARGIN  = FIFO_AE_MARGIN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] FIFO_data_out,
  output logic [DATA_WIDTH-1:0] FIFO_data_in,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [ADDR_WIDTH-1:0] rd_ptr,
  output logic                  write_enable,
  output logic                  read_enable,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_C    = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] AF_LEVEL = DEPTH_C - (ADDR_WIDTH+1)'(AF_MARGIN);
  localparam logic [ADDR_WIDTH:0] AE_LEVEL = (ADDR_WIDTH+1)'(AE_MARGIN);

  logic [ADDR_WIDTH:0] count_q, count_d;
  fifo_err_t           err_q, err_d;
  logic                pop_valid_q, pop_valid_d;
  logic                push_ok, pop_ok;

  // Handshake: push and pop are requests with no back-pressure port. A request
  // is accepted in the same cycle iff the registered flag allows it (push needs
  // ~full, pop needs ~empty); a rejected request only sets its sticky error bit.
  // Accepted pops return data one cycle later, marked by pop_valid.
  always_comb begin
    push_ok     = push & ~full & ~reset;
    pop_ok      = pop & ~empty & ~reset;
    count_d     = count_q;
    err_d       = err_q;
    pop_valid_d = pop_ok;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
    if (push && full) begin
      err_d.overflow = 1'b1;
    end
    if (pop && empty) begin
      err_d.underflow = 1'b1;
    end
    if (reset) begin
      count_d     = '0;
      err_d       = '0;
      pop_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    count_q     <= count_d;
    err_q       <= err_d;
    pop_valid_q <= pop_valid_d;
  end

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .en    (push_ok),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .en    (pop_ok),
    .ptr   (rd_ptr)
  );

  // Flags come only from the count register, never from this cycle's requests.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_LEVEL);
  assign almost_empty = (count_q <= AE_LEVEL);

  assign write_enable = push_ok;
  assign read_enable  = pop_ok;
  assign FIFO_data_in = push_data;
  assign pop_data     = FIFO_data_out;
  assign pop_valid    = pop_valid_q;
  assign count        = count_q;
  assign overflow     = err_q.overflow;
  assign underflow    = err_q.underflow;

endmodule
